// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and writeback-select helper for the MEM/WB pipeline register.
package mem_wb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_ADDR_W_DEF = 5;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    typedef struct packed {
        logic                      wb_en;
        logic                      mem_r_en;
        logic [DATA_W_DEF-1:0]     alu_result;
        logic [DATA_W_DEF-1:0]     mem_r_value;
        logic [REG_ADDR_W_DEF-1:0] dest;
    } mem_wb_payload_t;

    function automatic logic [DATA_W_DEF-1:0] wb_select(input mem_wb_payload_t p);
        return p.mem_r_en ? p.mem_r_value : p.alu_result;
    endfunction
endpackage

// File: rtl/mem_wb_pipe_reg_if.sv
// mem_wb_pipe_reg_if: MEM-side input and WB-side output bundle of the MEM/WB register.
interface mem_wb_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  wb_en_in;
    logic                  mem_r_en_in;
    logic [DATA_W-1:0]     alu_result_in;
    logic [DATA_W-1:0]     mem_r_value_in;
    logic [REG_ADDR_W-1:0] dest_in;
    logic                  out_valid;
    logic                  out_ready;
    logic                  wb_en;
    logic                  mem_r_en;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_r_value;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     wb_data;
    logic                  fwd_en;

    modport master (
        output in_valid, wb_en_in, mem_r_en_in, alu_result_in, mem_r_value_in, dest_in, out_ready,
        input  in_ready, out_valid, wb_en, mem_r_en, alu_result, mem_r_value, dest, wb_data, fwd_en
    );
    modport slave (
        input  in_valid, wb_en_in, mem_r_en_in, alu_result_in, mem_r_value_in, dest_in, out_ready,
        output in_ready, out_valid, wb_en, mem_r_en, alu_result, mem_r_value, dest, wb_data, fwd_en
    );
endinterface

// File: rtl/wb_data_sel.sv
// wb_data_sel: load-data / ALU-result writeback mux, shared with the forwarding path.
module wb_data_sel #(
    parameter int DATA_W = 32
) (
    input  logic              mem_r_en,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_r_value,
    output logic [DATA_W-1:0] wb_data
);
    assign wb_data = mem_r_en ? mem_r_value : alu_result;
endmodule

// File: rtl/mem_wb_pipe_reg.sv
// mem_wb_pipe_reg: MEM/WB pipeline register with skid buffer, flush and bubble-qualified control.
module mem_wb_pipe_reg
    import mem_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SUPPRESS_R0 = 1'b1
) (
    input logic                clk,
    input logic                rst,
    input logic                flush,
    mem_wb_pipe_reg_if.slave   bus
);
    typedef struct packed {
        logic                  wb_en;
        logic                  mem_r_en;
        logic [DATA_W-1:0]     alu_result;
        logic [DATA_W-1:0]     mem_r_value;
        logic [REG_ADDR_W-1:0] dest;
    } payload_t;

    state_t   state;
    payload_t main_q, skid_q, in_p;
    logic     ready_q, accept, retire, r0;

    assign in_p   = '{bus.wb_en_in, bus.mem_r_en_in, bus.alu_result_in, bus.mem_r_value_in, bus.dest_in};
    assign accept = bus.in_valid & ready_q;
    assign retire = bus.out_valid & bus.out_ready;
    assign r0     = SUPPRESS_R0 && (main_q.dest == '0);

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = (state != EMPTY);
    assign bus.wb_en       = bus.out_valid & main_q.wb_en & ~r0;
    assign bus.mem_r_en    = bus.out_valid & main_q.mem_r_en;
    assign bus.alu_result  = main_q.alu_result;
    assign bus.mem_r_value = main_q.mem_r_value;
    assign bus.dest        = main_q.dest;
    assign bus.fwd_en      = bus.wb_en;

    wb_data_sel #(.DATA_W(DATA_W)) u_sel (
        .mem_r_en   (main_q.mem_r_en),
        .alu_result (main_q.alu_result),
        .mem_r_value(main_q.mem_r_value),
        .wb_data    (bus.wb_data)
    );

    // ready is registered: it drops only when the skid slot fills, so MEM never sees a comb path from out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_q <= in_p;
                    state  <= FULL;
                end
                FULL: if (accept && retire) main_q <= in_p;
                else if (accept) begin
                    skid_q  <= in_p;
                    state   <= SKID;
                    ready_q <= 1'b0;
                end else if (retire) state <= EMPTY;
                SKID: if (retire) begin
                    main_q  <= skid_q;
                    state   <= FULL;
                    ready_q <= 1'b1;
                end
                default: state <= EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// tb_mem_wb_pipe_reg: scoreboard bench; a FIFO model of held entries predicts every output.
module tb_mem_wb_pipe_reg;
    typedef struct {
        logic [31:0] alu;
        logic [31:0] mv;
        logic [31:0] wd;
        logic [4:0]  d;
        logic        we0;
        logic        we1;
        logic        mr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic mon_on = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];

    mem_wb_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) i0 ();
    mem_wb_pipe_reg_if #(.DATA_W(32), .REG_ADDR_W(5)) i1 ();

    mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .SUPPRESS_R0(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(i0.slave)
    );
    mem_wb_pipe_reg #(.DATA_W(32), .REG_ADDR_W(5), .SUPPRESS_R0(1'b0)) dut_nosup (
        .clk(clk), .rst(rst), .flush(flush), .bus(i1.slave)
    );

    assign i1.in_valid       = i0.in_valid;
    assign i1.wb_en_in       = i0.wb_en_in;
    assign i1.mem_r_en_in    = i0.mem_r_en_in;
    assign i1.alu_result_in  = i0.alu_result_in;
    assign i1.mem_r_value_in = i0.mem_r_value_in;
    assign i1.dest_in        = i0.dest_in;
    assign i1.out_ready      = i0.out_ready;

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i0.in_valid = 1'b0;
    endtask

    // holds the item on the input until an edge accepts it; returns #1 after that edge
    task automatic push(input logic [31:0] a, input logic [31:0] m, input logic [4:0] d,
                        input logic we, input logic mr);
        logic ok;
        i0.in_valid = 1'b1;
        i0.alu_result_in = a;
        i0.mem_r_value_in = m;
        i0.dest_in = d;
        i0.wb_en_in = we;
        i0.mem_r_en_in = mr;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            ok = i0.in_ready;
            cyc();
        end
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    // monitor: model is the queue of held entries; capacity two, head drives outputs
    always @(negedge clk) begin
        if (mon_on) begin
            if (rst) q.delete();
            else begin
                chk("out_valid", {31'd0, i0.out_valid}, {31'd0, q.size() > 0});
                chk("in_ready", {31'd0, i0.in_ready}, {31'd0, q.size() < 2});
                chk("nosup_out_valid", {31'd0, i1.out_valid}, {31'd0, q.size() > 0});
                if (!i0.out_valid) begin
                    chk("bubble_wb_en", {31'd0, i0.wb_en}, 32'd0);
                    chk("bubble_mem_r_en", {31'd0, i0.mem_r_en}, 32'd0);
                    chk("bubble_fwd_en", {31'd0, i0.fwd_en}, 32'd0);
                end
                if (i0.out_valid && i0.out_ready && q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("alu_result", i0.alu_result, e.alu);
                    chk("mem_r_value", i0.mem_r_value, e.mv);
                    chk("dest", {27'd0, i0.dest}, {27'd0, e.d});
                    chk("wb_data", i0.wb_data, e.wd);
                    chk("wb_en", {31'd0, i0.wb_en}, {31'd0, e.we0});
                    chk("fwd_en", {31'd0, i0.fwd_en}, {31'd0, e.we0});
                    chk("mem_r_en", {31'd0, i0.mem_r_en}, {31'd0, e.mr});
                    chk("nosup_wb_en", {31'd0, i1.wb_en}, {31'd0, e.we1});
                    chk("nosup_wb_data", i1.wb_data, e.wd);
                end
                if (flush) q.delete();
                else if (i0.in_valid && i0.in_ready) begin
                    exp_t n;
                    n.alu = i0.alu_result_in;
                    n.mv  = i0.mem_r_value_in;
                    n.mr  = i0.mem_r_en_in;
                    n.wd  = i0.mem_r_en_in ? i0.mem_r_value_in : i0.alu_result_in;
                    n.d   = i0.dest_in;
                    n.we1 = i0.wb_en_in;
                    n.we0 = i0.wb_en_in && (i0.dest_in != 5'd0);
                    q.push_back(n);
                end
            end
        end
    end

    task automatic chk_zero(input string n);
        chk({n, "_out_valid"}, {31'd0, i0.out_valid}, 32'd0);
        chk({n, "_in_ready"}, {31'd0, i0.in_ready}, 32'd1);
        chk({n, "_wb_en"}, {31'd0, i0.wb_en}, 32'd0);
        chk({n, "_mem_r_en"}, {31'd0, i0.mem_r_en}, 32'd0);
        chk({n, "_fwd_en"}, {31'd0, i0.fwd_en}, 32'd0);
        chk({n, "_alu_result"}, i0.alu_result, 32'd0);
        chk({n, "_mem_r_value"}, i0.mem_r_value, 32'd0);
        chk({n, "_dest"}, {27'd0, i0.dest}, 32'd0);
        chk({n, "_wb_data"}, i0.wb_data, 32'd0);
    endtask

    initial begin
        i0.in_valid = 1'b0;
        i0.wb_en_in = 1'b0;
        i0.mem_r_en_in = 1'b0;
        i0.alu_result_in = '0;
        i0.mem_r_value_in = '0;
        i0.dest_in = '0;
        i0.out_ready = 1'b1;
        repeat (2) cyc();
        chk_zero("reset");
        rst = 1'b0;
        cyc();
        chk_zero("post_reset");
        mon_on = 1'b1;

        // streaming
        push(32'h10, 32'h0, 5'd3, 1'b1, 1'b0);
        chk("stream0_alu", i0.alu_result, 32'h10);
        chk("stream0_dest", {27'd0, i0.dest}, 32'd3);
        push(32'h20, 32'h0, 5'd4, 1'b1, 1'b0);
        chk("stream1_alu", i0.alu_result, 32'h20);
        chk("stream1_wb_data", i0.wb_data, 32'h20);
        push(32'h30, 32'h0, 5'd5, 1'b1, 1'b0);
        chk("stream2_dest", {27'd0, i0.dest}, 32'd5);
        chk("stream2_wb_en", {31'd0, i0.wb_en}, 32'd1);
        idle();
        repeat (2) cyc();

        // load select
        i0.out_ready = 1'b0;
        push(32'h1000, 32'hDEADBEEF, 5'd7, 1'b1, 1'b1);
        idle();
        chk("load_wb_data", i0.wb_data, 32'hDEADBEEF);
        chk("load_mem_r_en", {31'd0, i0.mem_r_en}, 32'd1);
        i0.out_ready = 1'b1;
        repeat (2) cyc();

        // stall with skid: out_ready low for the three cycles A is at the head
        fork
            begin
                push(32'hA, 32'h1, 5'd1, 1'b1, 1'b0);
                push(32'hB, 32'h2, 5'd2, 1'b1, 1'b1);
                push(32'hC, 32'h3, 5'd3, 1'b0, 1'b0);
                push(32'hD, 32'h4, 5'd4, 1'b1, 1'b0);
                idle();
            end
            begin
                cyc();
                i0.out_ready = 1'b0;
                cyc();
                chk("stall_in_ready", {31'd0, i0.in_ready}, 32'd0);
                chk("stall_head", i0.alu_result, 32'hA);
                cyc();
                cyc();
                i0.out_ready = 1'b1;
            end
        join
        repeat (4) cyc();
        chk("stall_drained", q.size(), 32'd0);

        // flush while in SKID with a live input
        i0.out_ready = 1'b0;
        push(32'h111, 32'h0, 5'd9, 1'b1, 1'b0);
        push(32'h222, 32'h0, 5'd10, 1'b1, 1'b0);
        chk("skid_entered", {31'd0, i0.in_ready}, 32'd0);
        i0.in_valid = 1'b1;
        i0.alu_result_in = 32'hBAD;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        idle();
        chk("flush_out_valid", {31'd0, i0.out_valid}, 32'd0);
        chk("flush_wb_en", {31'd0, i0.wb_en}, 32'd0);
        chk("flush_in_ready", {31'd0, i0.in_ready}, 32'd1);
        i0.out_ready = 1'b1;
        repeat (3) cyc();

        // R0 suppression, compared against the non-suppressing instance
        i0.out_ready = 1'b0;
        push(32'h55, 32'h0, 5'd0, 1'b1, 1'b0);
        idle();
        chk("r0_out_valid", {31'd0, i0.out_valid}, 32'd1);
        chk("r0_wb_en", {31'd0, i0.wb_en}, 32'd0);
        chk("r0_fwd_en", {31'd0, i0.fwd_en}, 32'd0);
        chk("r0_nosup_wb_en", {31'd0, i1.wb_en}, 32'd1);
        i0.out_ready = 1'b1;
        repeat (2) cyc();

        // reset during SKID loses both entries
        i0.out_ready = 1'b0;
        push(32'h333, 32'h5, 5'd11, 1'b1, 1'b1);
        push(32'h444, 32'h6, 5'd12, 1'b1, 1'b0);
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_zero("mid_stall_reset");
        i0.out_ready = 1'b1;
        cyc();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            i0.in_valid = ($urandom_range(0, 3) != 0);
            i0.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            i0.wb_en_in = $urandom_range(0, 1);
            i0.mem_r_en_in = $urandom_range(0, 1);
            i0.alu_result_in = $urandom;
            i0.mem_r_value_in = $urandom;
            i0.dest_in = 5'($urandom_range(0, 7));
            cyc();
        end
        flush = 1'b0;
        idle();
        i0.out_ready = 1'b1;
        repeat (5) cyc();
        chk("final_drain", q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
